// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a req/ack instruction
// memory port, prefetches into a small circular queue and presents the
// queue head to the IF/ID register. Redirects squash queued and in-flight
// fetches.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  HzCtrl,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC4,
  output logic [31:0] Inst,
  output logic        fetch_valid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, KILL} state_t;

  state_t         state, state_nxt;
  logic [31:0]    pc, pc_nxt;
  logic [31:0]    redirect_base;
  logic [31:0]    q_pc4  [DEPTH];
  logic [31:0]    q_inst [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count, count_after;
  logic           consume, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redirect_base = redirect_pc & ~32'h0000_0003;
  assign consume       = (HzCtrl == 2'b00) || (HzCtrl == 2'b01);

  // Next-state, next-pc and queue push/pop decisions; redirect dominates.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    push        = 1'b0;
    pop         = consume && (count != '0) && !redirect_valid;
    count_after = count;
    case (state)
      IDLE: begin
        if (redirect_valid)
          pc_nxt = redirect_base;
        else if (count < CW'(DEPTH))
          state_nxt = BUSY;
      end
      BUSY: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_base;
          state_nxt = imem_ack ? IDLE : KILL;
        end else if (imem_ack) begin
          push        = 1'b1;
          pc_nxt      = pc + 32'd4;
          count_after = count + CW'(1) - CW'(pop);
          state_nxt   = (count_after < CW'(DEPTH)) ? BUSY : IDLE;
        end
      end
      KILL: begin
        // The outstanding ack is dropped; a later redirect only moves pc.
        if (redirect_valid)
          pc_nxt = redirect_base;
        if (imem_ack)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // PC and queue bookkeeping; a redirect empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      pc <= pc_nxt;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (pop)
          rd_ptr <= ptr_inc(rd_ptr);
        if (push)
          wr_ptr <= ptr_inc(wr_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage; contents only matter while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc4[wr_ptr]  <= pc + 32'd4;
      q_inst[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req    = (state == BUSY);
  assign imem_addr   = pc;
  assign fetch_valid = (count != '0);
  assign PC4         = fetch_valid ? q_pc4[rd_ptr]  : '0;
  assign Inst        = fetch_valid ? q_inst[rd_ptr] : '0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, streaming, stall, redirect
// during/with ack, PC wrap and reset mid-request.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  HzCtrl;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC4;
  logic [31:0] Inst;
  logic        fetch_valid;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .HzCtrl         (HzCtrl),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .PC4            (PC4),
    .Inst           (Inst),
    .fetch_valid    (fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h13A5_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and drop the one-cycle pulses.
  task automatic step();
    @(negedge clk);
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    HzCtrl         = 2'b00;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;

    // T1 reset
    step();
    check("rst_req",   32'(imem_req), 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_pc4",   PC4, 32'h0);
    check("rst_inst",  Inst, 32'h0);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    rst = 1'b0;

    // T1 first request + T2 zero-wait stream
    for (int i = 0; i < 4; i++) begin
      step();
      check("strm_req",  32'(imem_req), 32'd1);
      check("strm_addr", imem_addr, 32'(4 * i));
      if (i == 0) begin
        check("strm_empty", 32'(fetch_valid), 32'd0);
      end else begin
        check("strm_pc4",  PC4, 32'(4 * i));
        check("strm_inst", Inst, mem_word(32'(4 * (i - 1))));
      end
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end

    // T3 stall: fill to DEPTH, request drops, head held
    step();
    check("stl_pc4_0", PC4, 32'd16);
    HzCtrl     = 2'b10;
    imem_ack   = 1'b1;
    imem_rdata = mem_word(32'd16);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stl_req",  32'(imem_req), 32'd0);
      check("stl_pc4",  PC4, 32'd16);
      check("stl_inst", Inst, mem_word(32'd12));
    end
    step();
    HzCtrl = 2'b00;
    step();
    check("res_pc4",  PC4, 32'd20);
    check("res_inst", Inst, mem_word(32'd16));
    step();
    check("res_empty", 32'(fetch_valid), 32'd0);
    check("res_req",   32'(imem_req), 32'd1);
    check("res_addr",  imem_addr, 32'd20);

    // T4 redirect mid-request, ack arrives 3 cycles after request
    step();
    check("t4_hold_addr", imem_addr, 32'd20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    step();
    check("t4_kill_req", 32'(imem_req), 32'd0);
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    check("t4_no_stale", Inst, 32'h0);
    check("t4_valid",    32'(fetch_valid), 32'd0);
    step();
    check("t4_req",  32'(imem_req), 32'd1);
    check("t4_addr", imem_addr, 32'h0000_0100);
    check("t4_inst", Inst, 32'h0);

    // T5 redirect coincident with ack
    imem_ack       = 1'b1;
    imem_rdata     = 32'hBAD1_BAD1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    check("t5_inst",  Inst, 32'h0);
    check("t5_valid", 32'(fetch_valid), 32'd0);
    check("t5_pc",    imem_addr, 32'h0000_0100);
    step();
    check("t5_req",  32'(imem_req), 32'd1);
    check("t5_addr", imem_addr, 32'h0000_0100);

    // T6 PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD2_BAD2;
    step();
    step();
    check("t6_req",  32'(imem_req), 32'd1);
    check("t6_addr", imem_addr, 32'hFFFF_FFFC);
    HzCtrl     = 2'b10;
    imem_ack   = 1'b1;
    imem_rdata = mem_word(32'hFFFF_FFFC);
    step();
    check("t6_pc4",   PC4, 32'h0000_0000);
    check("t6_inst",  Inst, mem_word(32'hFFFF_FFFC));
    check("t6_valid", 32'(fetch_valid), 32'd1);
    check("t6_next",  imem_addr, 32'h0000_0000);

    // Reset mid-request, then a stale ack while idle
    rst = 1'b1;
    #1;
    check("mrst_req",   32'(imem_req), 32'd0);
    check("mrst_valid", 32'(fetch_valid), 32'd0);
    step();
    rst        = 1'b0;
    HzCtrl     = 2'b00;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD3_BAD3;
    step();
    check("stale_valid", 32'(fetch_valid), 32'd0);
    check("stale_req",   32'(imem_req), 32'd1);
    check("stale_addr",  imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
